instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch stage of the pipelined 64-bit ARM CPU.
- Owns the program counter and drives the byte address into the combinational instruction ROM.
- Captures the returned 32-bit word into the IF/ID pipeline register.
- Takes stall from the hazard unit and branch redirect from the execute stage; flags a sticky fault on illegal fetch addresses.

Parameters:
- RESET_PC, 64'd0, byte address fetched first after reset; must be word-aligned.
- IMEM_BYTES, 1024, instruction ROM size in bytes; power of two, >4; must match ROM.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- redirect  in  1  branch/jump resolved taken; load redirect_target
- redirect_target  in  64  byte address of the next instruction on redirect
- imem_addr  out  64  byte address to instruction ROM; equals PC, combinational
- imem_instr  in  32  ROM read data for imem_addr, same cycle
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  latched instruction; NOP_INSTR when not valid
- if_id_pc  out  64  byte address of if_id_instr
- fault  out  1  sticky illegal-fetch flag
- fetch_count  out  32  number of instructions latched valid into IF/ID

Behaviour:
- Reset (synchronous, active-high; reset values):
  - pc=RESET_PC, state=S_RUN.
  - if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0.
  - fault=0, fetch_count=0.
- ROM interface: imem_addr=pc at all times, including during reset. The ROM is zero-latency, so imem_instr is sampled at the same edge that advances pc.
- Fetch address legality: a fetch address is legal when addr[1:0]==0 and addr+3 < IMEM_BYTES.
- States: S_RUN, S_FAULT.
- S_RUN, evaluated per edge in priority order:
  1. redirect=1 (overrides stall):
     - If redirect_target is legal: pc<=redirect_target. IF/ID is flushed (valid=0, instr=NOP_INSTR, if_id_pc=0). fetch_count is unchanged.
     - If redirect_target is illegal: IF/ID is flushed, pc holds, next state is S_FAULT.
  2. stall=1: pc, IF/ID and fetch_count all hold.
  3. Otherwise, if pc is illegal: IF/ID is flushed, pc holds, next state is S_FAULT.
  4. Otherwise:
     - IF/ID<={valid=1, instr=imem_instr, pc=pc}.
     - pc<=pc+4 (64-bit, modulo 2^64).
     - fetch_count<=fetch_count+1, wrapping modulo 2^32.
- S_FAULT:
  - fault=1 (registered; asserts the cycle after the fault edge).
  - pc frozen; IF/ID held flushed.
  - stall and redirect are ignored.
  - Only reset exits, returning to S_RUN.
- Latency:
  - An instruction at address A appears in IF/ID one edge after pc==A with no stall.
  - After a redirect edge there is exactly one bubble cycle; the target instruction is valid on the following edge.
- Simultaneous events:
  - reset overrides everything.
  - redirect overrides stall, because the redirect comes from an older instruction.
  - stall does not protect against a pending illegal pc; the fault is detected on the first unstalled edge.
- Reset mid-operation: the entire state returns to reset values on that edge, with no partial update.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR constant (32'hD503201F).
  - typedef if_id_t (valid, instr[31:0], pc[63:0]).
  - fetch state enum {S_RUN, S_FAULT}.
  - Helper function addr_legal(addr, size).
- One natural sub-module: pc_reg. It is the 64-bit PC register with load/hold/increment controls and synchronous reset to RESET_PC.
- IF/ID capture and the FSM stay in instr_fetch.

Test Plan:
- Reset, then 4 unstalled edges with the ROM model returning 32'h91000421 at every address:
  - imem_addr steps 0, 4, 8, 12, 16.
  - if_id_pc runs 0, 4, 8, 12; if_id_valid=1 from edge 1.
  - fetch_count=4.
- With pc=8, hold stall=1 for 3 cycles:
  - pc stays 8; IF/ID unchanged; fetch_count unchanged.
  - On release, if_id_pc=8 and pc=12.
- With pc=16: redirect=1, redirect_target=64, and stall=1 in the same cycle:
  - Next edge: pc=64, if_id_valid=0, if_id_instr=NOP_INSTR.
  - Following edge: if_id_pc=64, valid=1.
- redirect_target=66 (misaligned):
  - Next edge: state S_FAULT, fault=1, pc frozen, if_id_valid=0.
  - Later redirect and stall pulses have no effect.
  - reset returns pc=0 and fault=0.
- Run sequentially from RESET_PC=1016 with IMEM_BYTES=1024:
  - Instructions at 1016 and 1020 latch valid.
  - At pc=1024, fault=1 and fetch_count=2.
- Preload fetch_count near wrap (force 32'hFFFFFFFF), then one valid fetch: fetch_count=0, and the fetch is otherwise unaffected.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and helpers for the CPU front end.
//   NOP_INSTR   - encoding placed in IF/ID whenever it holds no real instruction
//   if_id_t     - IF/ID pipeline register contents
//   fetch_state_t - fetch FSM states
//   addr_legal  - word-aligned, fully-inside-ROM check for a fetch address
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } if_id_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } fetch_state_t;

  localparam if_id_t IF_ID_FLUSH = '{valid: 1'b0, instr: NOP_INSTR, pc: 64'd0};

  // Legal when aligned and all four bytes lie inside the ROM. Written as
  // addr < size-3 rather than addr+3 < size so an address near 2^64 cannot
  // wrap around and look legal. size is always > 4, so size-3 cannot underflow.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] size);
    addr_legal = (addr[1:0] == 2'b00) && (addr < (size - 64'd3));
  endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 64-bit program counter.
//   i_clk, i_reset  - clock, synchronous active-high reset (to RESET_PC)
//   i_load/i_load_val - load a new PC (wins over increment)
//   i_inc           - advance by one instruction (+4, modulo 2^64)
//   o_pc            - current PC
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [63:0] i_load_val,
  input  logic        i_inc,
  output logic [63:0] o_pc
);

  logic [63:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_val;
    else if (i_inc)  r_pc <= r_pc + 64'd4;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage.
//   i_clk, i_reset        - clock, synchronous active-high reset
//   i_stall               - hold PC, IF/ID and fetch count
//   i_redirect, i_redirect_target - taken branch/jump; overrides stall
//   o_imem_addr           - byte address to the combinational ROM (= PC)
//   i_imem_instr          - ROM data for o_imem_addr, same cycle
//   o_if_id_valid/instr/pc - IF/ID pipeline register
//   o_fault               - sticky illegal-fetch flag, cleared only by reset
//   o_fetch_count         - instructions latched valid into IF/ID (wraps)
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_target,
  output logic [63:0] o_imem_addr,
  input  logic [31:0] i_imem_instr,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [63:0] o_if_id_pc,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);

  localparam logic [63:0] SIZE = 64'(IMEM_BYTES);

  fetch_state_t r_state, w_state_nxt;
  if_id_t       r_if_id, w_if_id_nxt;
  logic [31:0]  r_fetch_count;
  logic [63:0]  w_pc;
  logic         w_pc_load, w_pc_inc, w_cnt_inc;
  logic         w_pc_legal, w_tgt_legal;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_pc_load),
    .i_load_val (i_redirect_target),
    .i_inc      (w_pc_inc),
    .o_pc       (w_pc)
  );

  assign w_pc_legal  = addr_legal(w_pc, SIZE);
  assign w_tgt_legal = addr_legal(i_redirect_target, SIZE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_RUN;
      r_if_id       <= IF_ID_FLUSH;
      r_fetch_count <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_if_id <= w_if_id_nxt;
      if (w_cnt_inc) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_if_id_nxt = r_if_id;
    w_pc_load   = 1'b0;
    w_pc_inc    = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_redirect) begin
          // Redirect comes from an older instruction, so it beats stall.
          w_if_id_nxt = IF_ID_FLUSH;
          if (w_tgt_legal) w_pc_load   = 1'b1;
          else             w_state_nxt = S_FAULT;
        end else if (i_stall) begin
          // hold everything; an illegal PC is caught on the first free edge
        end else if (!w_pc_legal) begin
          w_if_id_nxt = IF_ID_FLUSH;
          w_state_nxt = S_FAULT;
        end else begin
          w_if_id_nxt = '{valid: 1'b1, instr: i_imem_instr, pc: w_pc};
          w_pc_inc    = 1'b1;
          w_cnt_inc   = 1'b1;
        end
      end
      S_FAULT: begin
        w_if_id_nxt = IF_ID_FLUSH;
      end
      default: begin
        w_state_nxt = S_FAULT;
        w_if_id_nxt = IF_ID_FLUSH;
      end
    endcase
  end

  assign o_imem_addr   = w_pc;
  assign o_if_id_valid = r_if_id.valid;
  assign o_if_id_instr = r_if_id.instr;
  assign o_if_id_pc    = r_if_id.pc;
  assign o_fault       = (r_state == S_FAULT);
  assign o_fetch_count = r_fetch_count;

endmodule
